bram_req_ctrl: RTL
==================

// Module: bram_req_ctrl
// PURPOSE
//  Initiator-side front end for the single-port block RAM wrapper (brams).
//  - Converts a valid/ready request stream (read or write) into BRAM port cycles.
//  - Tracks the BRAM's 2-clock registered read latency.
//  - Returns read data on a valid/ready response stream, with an internal FIFO
//    that absorbs in-flight reads under back-pressure.
//  - Sits between any client (CPU load/store unit, DMA) and one brams instance.
// PARAMETERS
//  ADDR_      8  BRAM address width (matches brams ADDR_)
//  DATA_      8  BRAM data width (matches brams DATA_)
//  RSP_DEPTH  4  response FIFO entries; power of 2, >=4 (elaboration $error otherwise)
// PORTS
//  clk        in   1      clock
//  aclr       in   1      reset, synchronous, active-high
//  req_valid  in   1      request present
//  req_ready  out  1      request accepted this cycle when req_valid && req_ready
//  req_we     in   1      1 = write, 0 = read
//  req_addr   in   ADDR_  request address
//  req_wdata  in   DATA_  write data (ignored for reads)
//  rsp_valid  out  1      read data available
//  rsp_ready  in   1      consumer takes rsp_rdata when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_  read data, in request order
//  mem_aclr   out  1      to brams aclr; equals aclr
//  mem_we     out  1      to brams we
//  mem_addr   out  ADDR_  to brams addr
//  mem_din    out  DATA_  to brams din
//  mem_dout   in   DATA_  from brams dout
// BEHAVIOUR
//  Reset (aclr=1 at a clk edge)
//  - Clears v1, v2, FIFO pointers and count.
//  - While aclr=1: req_ready=0, mem_we=0, rsp_valid=0.
//  - In-flight reads are dropped and never returned.
//  - Writes already issued to the BRAM stand (not undone).
//  Credit
//  - req_ready = !aclr && (count + v1 + v2 < RSP_DEPTH), all registered terms.
//  - Same rule for reads and writes; no combinational path from req_* to req_ready.
//  - Same-cycle pop does NOT add credit.
//  Issue path (combinational; brams registers its inputs)
//  - mem_addr = req_addr; mem_din = req_wdata.
//  - mem_we = req_valid && req_ready && req_we.
//  - Read accepted: req_valid && req_ready && !req_we.
//  Latency pipeline
//  - v1 <= read accepted; v2 <= v1.
//  - When v2=1, mem_dout is valid and is pushed into the FIFO at that edge.
//  - Read accepted in cycle t -> rsp_valid=1 in cycle t+3 earliest (3-cycle latency).
//  - One request per cycle max; writes have no response.
//  FIFO
//  - Storage DATA_ x RSP_DEPTH; wr_ptr/rd_ptr are clog2(RSP_DEPTH) bits, wrap modulo RSP_DEPTH.
//  - count is clog2(RSP_DEPTH+1) bits.
//  - rsp_valid = (count != 0); rsp_rdata = mem[rd_ptr], first-word fall-through.
//  - Pop on rsp_valid && rsp_ready.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//  - Overflow is impossible by credit rule; simulation assertion: push && count==RSP_DEPTH -> $error.
//  - Pop on empty is impossible (gated by rsp_valid).
//  Throughput and ordering
//  - RSP_DEPTH>=4 with rsp_ready held 1: steady state count+v1+v2 <= 3, so back-to-back
//    reads sustain 1 per clk.
//  - Responses strictly in request order.
//  - Write then read to the same address in consecutive cycles returns the new data
//    (BRAM ports are serialized).
// TESTING
//  1 Reset: hold aclr 3 clks mid-stream -> req_ready=0, mem_we=0, rsp_valid=0; no stale response afterwards.
//  2 Write 0xA5@0x10, then read 0x10 in next cycle, rsp_ready=1 -> rsp_rdata=0xA5, rsp_valid exactly 3 cycles after read accept.
//  3 16 back-to-back reads of addr 0..15 (preloaded data=addr^0xFF), rsp_ready=1 -> req_ready stays 1; 16 responses in order, one per clk.
//  4 rsp_ready=0, issue reads continuously -> exactly 4 accepted, then req_ready=0; assert rsp_ready -> 4 correct responses, req_ready returns 1.
//  5 Push/pop same cycle with count=RSP_DEPTH-1 and wrap of rd_ptr/wr_ptr past 3 -> data order intact, count unchanged.
//  6 Writes with rsp_ready=0 and FIFO full -> req_ready=0 (writes stall too); no mem_we pulse until credit frees.

Source files
------------

// File: rtl/bram_req_ctrl.sv
// Valid/ready front end for a single-port BRAM with a 2-clock registered read path.
// Credit-limited issue, read-latency tracking and a fall-through response FIFO.
module bram_req_ctrl #(
  parameter int ADDR_     = 8,
  parameter int DATA_     = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDR_-1:0] req_addr,
  input  logic [DATA_-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATA_-1:0] rsp_rdata,
  output logic             mem_aclr,
  output logic             mem_we,
  output logic [ADDR_-1:0] mem_addr,
  output logic [DATA_-1:0] mem_din,
  input  logic [DATA_-1:0] mem_dout
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  generate
    if (RSP_DEPTH < 4 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bram_req_ctrl: RSP_DEPTH must be a power of 2 and >= 4");
    end
  endgenerate

  logic             r_vld_p1;
  logic             r_vld_p2;
  logic [DATA_-1:0] r_fifo [RSP_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW:0]      w_inflight;
  logic             w_req_fire;
  logic             w_rd_accept;
  logic             w_push;
  logic             w_pop;

  // Every accepted read owns a FIFO slot from issue until it is popped.
  assign w_inflight  = (CW+1)'(r_count) + (CW+1)'(r_vld_p1) + (CW+1)'(r_vld_p2);
  assign req_ready   = !aclr && (w_inflight < (CW+1)'(RSP_DEPTH));
  assign w_req_fire  = req_valid && req_ready;
  assign w_rd_accept = w_req_fire && !req_we;

  assign mem_aclr = aclr;
  assign mem_we   = w_req_fire && req_we;
  assign mem_addr = req_addr;
  assign mem_din  = req_wdata;

  // Stage p1: address held in the BRAM input register; p2: BRAM output register valid
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_accept;
      r_vld_p2 <= r_vld_p1;
    end
  end

  assign w_push    = r_vld_p2;
  assign rsp_valid = !aclr && (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_rdata = r_fifo[r_rd_ptr];

  // Response FIFO: storage is not reset, only pointers and occupancy
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!aclr) begin
      assert (!(w_push && r_count == CW'(RSP_DEPTH)))
        else $error("bram_req_ctrl: response FIFO overflow");
    end
  end
`endif

endmodule
